// File: rtl/vpi_pkg.sv
// Shared definitions for the video-input DDR line writer.
// Holds the writer FSM encoding, the controller write command code,
// the line counter width and the beats-per-line normalisation helper.
package vpi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAck,
        StPref,
        StWr,
        StDone
    } wr_state_e;

    localparam logic [2:0] APP_CMD_WR = 3'b000;

    localparam int unsigned LINE_CNT_W = 12;
    localparam logic [LINE_CNT_W-1:0] LINE_CNT_MAX = '1;

    // Zero means one beat; anything past 256 is held at 256 so the 8-bit
    // beat counter always reaches the last beat.
    function automatic logic [8:0] eff_beats(input logic [8:0] beats);
        if (beats == 9'd0) begin
            return 9'd1;
        end else if (beats > 9'd256) begin
            return 9'd256;
        end
        return beats;
    endfunction

endpackage

// File: rtl/vpi_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Ports:
//   clk      destination clock
//   rst_n    synchronous active-low reset
//   async_in asynchronous level input
//   rise     one-cycle pulse on a synchronised rising edge
module vpi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    // [1:0] synchroniser stages, [2] edge-detect history
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/vpi_ddr_line_writer.sv
// Video-input DDR line writer: on each line request from the ping-pong line
// RAM stage, acks the request, reads the buffered line out of the RAM and
// writes it to DDR3 through the controller's native app interface, one
// 128-bit beat per write command.
// Ports:
//   i_ddr_clk, i_rst_n, i_soft_rst   clock, sync active-low reset, soft reset
//   i_vs, i_ddr_req                  async vsync / line request (synchronised)
//   i_frame_base, i_line_beats       frame base address, beats per line
//   o_ddr_vpi_ack, o_ddr_wr_done     line accepted / line written pulses
//   o_ram_rd_addr, i_ram_rd_data     line RAM read port (1-cycle latency)
//   o_app_*, i_app_rdy, i_app_wdf_rdy controller command and write-data channels
//   o_line_overrun, o_line_cnt       sticky overrun flag, lines since vsync
module vpi_ddr_line_writer
    import vpi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned ADDR_WIDTH  = 27,
    parameter int unsigned ADDR_STEP   = 8,
    parameter int unsigned LINE_STRIDE = 2048
) (
    input  logic                  i_ddr_clk,
    input  logic                  i_rst_n,
    input  logic                  i_soft_rst,
    input  logic                  i_vs,
    input  logic                  i_ddr_req,
    input  logic [ADDR_WIDTH-1:0] i_frame_base,
    input  logic [8:0]            i_line_beats,
    output logic                  o_ddr_vpi_ack,
    output logic                  o_ddr_wr_done,
    output logic [7:0]            o_ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
    output logic                  o_app_en,
    output logic [2:0]            o_app_cmd,
    output logic [ADDR_WIDTH-1:0] o_app_addr,
    input  logic                  i_app_rdy,
    output logic                  o_app_wdf_wren,
    output logic                  o_app_wdf_end,
    output logic [DATA_WIDTH-1:0] o_app_wdf_data,
    input  logic                  i_app_wdf_rdy,
    output logic                  o_line_overrun,
    output logic [LINE_CNT_W-1:0] o_line_cnt
);

    logic srst_n;
    logic req_rise;
    logic vs_rise;

    assign srst_n = i_rst_n & ~i_soft_rst;

    vpi_sync_edge u_req_sync (
        .clk      (i_ddr_clk),
        .rst_n    (srst_n),
        .async_in (i_ddr_req),
        .rise     (req_rise)
    );

    vpi_sync_edge u_vs_sync (
        .clk      (i_ddr_clk),
        .rst_n    (srst_n),
        .async_in (i_vs),
        .rise     (vs_rise)
    );

    wr_state_e             state_q, state_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [8:0]            beats_q, beats_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic                  vs_pend_q, vs_pend_d;
    logic                  overrun_q, overrun_d;

    logic                  fire;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] line_off;

    assign fire      = (state_q == StWr) && i_app_rdy && i_app_wdf_rdy;
    assign last_beat = ({1'b0, beat_cnt_q} == (beats_q - 9'd1));
    assign line_off  = ADDR_WIDTH'(line_cnt_q) * ADDR_WIDTH'(LINE_STRIDE);

    always_ff @(posedge i_ddr_clk) begin
        if (!srst_n) begin
            state_q    <= StIdle;
            beat_cnt_q <= 8'd0;
            beats_q    <= 9'd1;
            addr_q     <= '0;
            line_cnt_q <= '0;
            vs_pend_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            beats_q    <= beats_d;
            addr_q     <= addr_d;
            line_cnt_q <= line_cnt_d;
            vs_pend_q  <= vs_pend_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        beats_d        = beats_q;
        addr_d         = addr_q;
        line_cnt_d     = line_cnt_q;
        vs_pend_d      = vs_pend_q;
        overrun_d      = overrun_q;
        o_ddr_vpi_ack  = 1'b0;
        o_ddr_wr_done  = 1'b0;
        o_ram_rd_addr  = 8'd0;
        o_app_en       = 1'b0;
        o_app_wdf_wren = 1'b0;
        o_app_wdf_end  = 1'b0;

        case (state_q)
            StIdle: begin
                if (vs_rise) begin
                    line_cnt_d = '0;
                end
                if (req_rise) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                o_ddr_vpi_ack = 1'b1;
                beats_d       = eff_beats(i_line_beats);
                beat_cnt_d    = 8'd0;
                // Line start address; the running address then steps per beat.
                addr_d        = i_frame_base + line_off;
                state_d       = StPref;
            end
            StPref: begin
                // Address 0 is presented so beat 0 data is ready on entry to WR.
                state_d = StWr;
            end
            StWr: begin
                o_app_en       = 1'b1;
                o_app_wdf_wren = 1'b1;
                o_app_wdf_end  = 1'b1;
                // Look one beat ahead only when the current beat is consumed.
                o_ram_rd_addr  = fire ? (beat_cnt_q + 8'd1) : beat_cnt_q;
                if (fire) begin
                    if (last_beat) begin
                        state_d = StDone;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        addr_d     = addr_q + ADDR_WIDTH'(ADDR_STEP);
                    end
                end
            end
            StDone: begin
                o_ddr_wr_done = 1'b1;
                if (vs_pend_q || vs_rise) begin
                    line_cnt_d = '0;
                end else if (line_cnt_q != LINE_CNT_MAX) begin
                    line_cnt_d = line_cnt_q + 1'b1;
                end
                vs_pend_d = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (vs_rise && (state_q != StIdle) && (state_q != StDone)) begin
            vs_pend_d = 1'b1;
        end
        if (req_rise && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    assign o_app_cmd      = APP_CMD_WR;
    assign o_app_addr     = (state_q == StWr) ? addr_q : '0;
    assign o_app_wdf_data = (state_q == StWr) ? i_ram_rd_data : '0;
    assign o_line_overrun = overrun_q;
    assign o_line_cnt     = line_cnt_q;

endmodule

// File: tb/tb_vpi_ddr_line_writer.sv
// Self-checking bench for vpi_ddr_line_writer: a table of directed lines,
// hand-written sequences for vsync, overrun and reset corners, then random
// lines with random back-pressure, all checked against a line-level model.
module tb_vpi_ddr_line_writer;

    logic         clk;
    logic         i_rst_n;
    logic         i_soft_rst;
    logic         i_vs;
    logic         i_ddr_req;
    logic [26:0]  i_frame_base;
    logic [8:0]   i_line_beats;
    logic         o_ddr_vpi_ack;
    logic         o_ddr_wr_done;
    logic [7:0]   o_ram_rd_addr;
    logic [127:0] i_ram_rd_data;
    logic         o_app_en;
    logic [2:0]   o_app_cmd;
    logic [26:0]  o_app_addr;
    logic         i_app_rdy;
    logic         o_app_wdf_wren;
    logic         o_app_wdf_end;
    logic [127:0] o_app_wdf_data;
    logic         i_app_wdf_rdy;
    logic         o_line_overrun;
    logic [11:0]  o_line_cnt;

    vpi_ddr_line_writer dut (
        .i_ddr_clk      (clk),
        .i_rst_n        (i_rst_n),
        .i_soft_rst     (i_soft_rst),
        .i_vs           (i_vs),
        .i_ddr_req      (i_ddr_req),
        .i_frame_base   (i_frame_base),
        .i_line_beats   (i_line_beats),
        .o_ddr_vpi_ack  (o_ddr_vpi_ack),
        .o_ddr_wr_done  (o_ddr_wr_done),
        .o_ram_rd_addr  (o_ram_rd_addr),
        .i_ram_rd_data  (i_ram_rd_data),
        .o_app_en       (o_app_en),
        .o_app_cmd      (o_app_cmd),
        .o_app_addr     (o_app_addr),
        .i_app_rdy      (i_app_rdy),
        .o_app_wdf_wren (o_app_wdf_wren),
        .o_app_wdf_end  (o_app_wdf_end),
        .o_app_wdf_data (o_app_wdf_data),
        .i_app_wdf_rdy  (i_app_wdf_rdy),
        .o_line_overrun (o_line_overrun),
        .o_line_cnt     (o_line_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stall_pct = 0;
    int model_lcnt = 0;
    int ack_count = 0, done_count = 0, ack_cyc = 0, done_cyc = 0;

    logic [127:0] ram [256];
    logic [127:0] ram_q;
    logic [26:0]  fire_addr [$];
    logic [127:0] fire_data [$];
    logic         hold_pending = 1'b0;
    logic [26:0]  hold_addr;
    logic [127:0] hold_data;

    typedef struct packed {
        logic [26:0] base;
        logic [8:0]  beats;
        int          stall;
        logic [26:0] exp_first;
        logic [26:0] exp_last;
        int          exp_fires;
        int          exp_lcnt;
    } vec_t;

    vec_t vecs [6];

    always @(posedge clk) cyc <= cyc + 1;

    // Line RAM: registered read, data for the address of the previous cycle.
    always @(posedge clk) ram_q <= ram[o_ram_rd_addr];
    assign i_ram_rd_data = ram_q;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    // Random, independent back-pressure on both channels.
    initial begin
        i_app_rdy     = 1'b0;
        i_app_wdf_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_app_rdy     = (int'($urandom_range(99)) >= stall_pct);
            i_app_wdf_rdy = (int'($urandom_range(99)) >= stall_pct);
        end
    end

    always @(negedge clk) begin
        if (o_app_en || o_app_wdf_wren)
            check("chan_pair", {o_app_en, o_app_wdf_wren, o_app_wdf_end, o_app_cmd}, 6'b111000);
        if (hold_pending)
            check("stall_hold", {o_app_en, o_app_addr, o_app_wdf_data},
                  {1'b1, hold_addr, hold_data});
        hold_pending = o_app_en && !(i_app_rdy && i_app_wdf_rdy);
        hold_addr    = o_app_addr;
        hold_data    = o_app_wdf_data;
        if (o_app_en && i_app_rdy && i_app_wdf_rdy) begin
            fire_addr.push_back(o_app_addr);
            fire_data.push_back(o_app_wdf_data);
        end
        if (o_ddr_vpi_ack) begin
            ack_count++;
            ack_cyc = cyc;
        end
        if (o_ddr_wr_done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic pulse_req();
        i_ddr_req = 1'b1;
        tick(3);
        i_ddr_req = 1'b0;
    endtask

    // One full line against the model: beat k goes to
    // base + lines_since_vsync*2048 + k*8 (mod 2^27) and carries ram[k].
    task automatic run_line(input logic [26:0] base, input logic [8:0] beats, input int stall,
                            input bit vs_mid, input bit mid_req,
                            output logic [26:0] first_a, output logic [26:0] last_a,
                            output int nfire);
        int a0, d0, t, eff, bad_a, bad_d, rq, lc0;
        logic [26:0] ea;
        eff = (beats == 9'd0) ? 1 : int'(beats);
        lc0 = model_lcnt;
        fire_addr.delete();
        fire_data.delete();
        a0 = ack_count;
        d0 = done_count;
        stall_pct    = stall;
        i_frame_base = base;
        i_line_beats = beats;
        rq = cyc;
        pulse_req();
        t = 0;
        while (ack_count == a0 && t < 10) begin
            wait_neg();
            t++;
        end
        check("ack_seen", ack_count != a0, 1);
        check("ack_latency", ack_cyc - rq, 3);
        if (vs_mid) begin
            i_vs = 1'b1;
            tick(3);
            i_vs = 1'b0;
        end
        if (mid_req) begin
            tick(20);
            pulse_req();
        end
        t = 0;
        while (done_count == d0 && t < 20000) begin
            wait_neg();
            t++;
        end
        check("done_seen", done_count != d0, 1);
        if (stall == 0) check("ack_to_done", done_cyc - ack_cyc, eff + 2);
        tick(1);
        check("ack_count", ack_count - a0, 1);
        nfire = fire_addr.size();
        check("fire_count", nfire, eff);
        bad_a = 0;
        bad_d = 0;
        for (int k = 0; k < nfire && k < eff; k++) begin
            ea = 27'(longint'(base) + longint'(lc0) * 2048 + longint'(k) * 8);
            if (fire_addr[k] !== ea) bad_a++;
            if (fire_data[k] !== ram[k]) bad_d++;
        end
        check("fire_addr_bad", bad_a, 0);
        check("fire_data_bad", bad_d, 0);
        if (vs_mid) model_lcnt = 0;
        else if (model_lcnt < 4095) model_lcnt++;
        check("line_cnt", o_line_cnt, model_lcnt);
        first_a = (nfire > 0) ? fire_addr[0] : 27'd0;
        last_a  = (nfire > 0) ? fire_addr[nfire-1] : 27'd0;
        tick(2);
    endtask

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: got no end of test, expected completion within 90000 cycles");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0] fa, la;
        int nf, a0, t;

        vecs[0] = '{27'h0100000, 9'd240, 0,  27'h0100000, 27'h0100778, 240, 1};
        vecs[1] = '{27'h0100000, 9'd240, 0,  27'h0100800, 27'h0100F78, 240, 2};
        vecs[2] = '{27'h0100000, 9'd0,   0,  27'h0101000, 27'h0101000, 1,   3};
        vecs[3] = '{27'h7FFFFF0, 9'd4,   50, 27'h00017F0, 27'h0001808, 4,   4};
        vecs[4] = '{27'h0200000, 9'd256, 30, 27'h0202000, 27'h02027F8, 256, 5};
        vecs[5] = '{27'h0000000, 9'd1,   45, 27'h0002800, 27'h0002800, 1,   6};

        for (int k = 0; k < 256; k++) ram[k] = {$urandom, $urandom, $urandom, $urandom};

        i_rst_n      = 1'b0;
        i_soft_rst   = 1'b0;
        i_vs         = 1'b0;
        i_ddr_req    = 1'b0;
        i_frame_base = 27'd0;
        i_line_beats = 9'd0;
        tick(3);
        wait_neg();
        check("reset_outputs", {o_ddr_vpi_ack, o_ddr_wr_done, o_ram_rd_addr, o_app_en, o_app_cmd,
                                o_app_wdf_wren, o_app_wdf_end, o_line_overrun, o_line_cnt,
                                o_app_addr}, 0);
        check("reset_wdf_data", o_app_wdf_data, 0);
        i_rst_n = 1'b1;
        tick(3);

        for (int k = 0; k < 6; k++) begin
            run_line(vecs[k].base, vecs[k].beats, vecs[k].stall, 1'b0, 1'b0, fa, la, nf);
            check($sformatf("vec%0d_first", k), fa, vecs[k].exp_first);
            check($sformatf("vec%0d_last", k), la, vecs[k].exp_last);
            check($sformatf("vec%0d_fires", k), nf, vecs[k].exp_fires);
            check($sformatf("vec%0d_lcnt", k), o_line_cnt, vecs[k].exp_lcnt);
        end

        // Vsync while idle clears the line count right away.
        i_vs = 1'b1;
        tick(3);
        i_vs = 1'b0;
        tick(2);
        model_lcnt = 0;
        check("vs_idle_clear", o_line_cnt, 0);

        // Vsync mid-line: the line still lands at line 1, then the count clears.
        run_line(27'h0300000, 9'd32, 0, 1'b0, 1'b0, fa, la, nf);
        run_line(27'h0300000, 9'd32, 20, 1'b1, 1'b0, fa, la, nf);
        check("vs_mid_first", fa, 27'h0300800);
        check("vs_mid_lcnt", o_line_cnt, 0);

        // Overrun: a second request during WR is dropped and flagged stickily.
        check("overrun_pre", o_line_overrun, 0);
        run_line(27'h0400000, 9'd200, 0, 1'b0, 1'b1, fa, la, nf);
        check("overrun_set", o_line_overrun, 1);
        run_line(27'h0400000, 9'd16, 25, 1'b0, 1'b0, fa, la, nf);
        check("overrun_sticky", o_line_overrun, 1);

        i_soft_rst = 1'b1;
        tick(1);
        i_soft_rst = 1'b0;
        model_lcnt = 0;
        wait_neg();
        check("soft_rst_clear", {o_line_overrun, o_line_cnt}, 0);
        tick(3);

        // Hard reset at beat 100 of a line, held two cycles.
        run_line(27'h0500000, 9'd8, 0, 1'b0, 1'b0, fa, la, nf);
        stall_pct    = 0;
        i_frame_base = 27'h0500000;
        i_line_beats = 9'd240;
        fire_addr.delete();
        fire_data.delete();
        a0 = ack_count;
        pulse_req();
        t = 0;
        while (fire_addr.size() < 100 && t < 400) begin
            wait_neg();
            t++;
        end
        check("reach_beat100", fire_addr.size() >= 100, 1);
        check("mid_line_ack", ack_count - a0, 1);
        i_rst_n = 1'b0;
        tick(1);
        wait_neg();
        check("midrst_outputs", {o_ddr_vpi_ack, o_ddr_wr_done, o_ram_rd_addr, o_app_en,
                                 o_app_cmd, o_app_wdf_wren, o_app_wdf_end, o_line_overrun,
                                 o_line_cnt, o_app_addr}, 0);
        check("midrst_wdf_data", o_app_wdf_data, 0);
        tick(1);
        i_rst_n = 1'b1;
        model_lcnt = 0;
        tick(3);
        run_line(27'h0500000, 9'd240, 0, 1'b0, 1'b0, fa, la, nf);
        check("restart_first", fa, 27'h0500000);
        check("restart_lcnt", o_line_cnt, 1);

        // Random lines, random back-pressure, occasional vsyncs.
        for (int r = 0; r < 20; r++) begin
            logic [26:0] rb;
            logic [8:0]  rbeats;
            if ($urandom_range(4) == 0) begin
                i_vs = 1'b1;
                tick(3);
                i_vs = 1'b0;
                tick(2);
                model_lcnt = 0;
                check("rand_vs_idle", o_line_cnt, 0);
            end
            rb     = 27'($urandom);
            rbeats = 9'($urandom_range(64));
            run_line(rb, rbeats, int'($urandom_range(50)), ($urandom_range(3) == 0), 1'b0,
                     fa, la, nf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
